move_commit_writer: RTL and testbench

- Write-side counterpart to the move-legality checks: takes an accepted move (source square, destination square) and commits it to the 64-square board RAM.
- Reads both squares and applies the colour/ownership rule. On success it writes the moving piece to the destination and clears the source.
- Tracks side-to-move and reports any captured piece.
- Sits between the move-entry/cursor logic and the board memory that the VGA renderer also reads.

---
 rtl/move_commit_writer.sv | 141 ++++++++++++++
 tb/tb_move_commit_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_commit_writer.sv
// Commits an accepted move to the board RAM: read src/dst, check colour/ownership, write dst, clear src.
// Optional pawn auto-promotion to queen on the far rank when AUTO_PROMOTE_EN is defined.
module move_commit_writer #(
  parameter int unsigned SQ_W       = 6,
  parameter int unsigned PIECE_W    = 4,
  parameter logic        START_TURN = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SQ_W-1:0]    req_src,
  input  logic [SQ_W-1:0]    req_dst,
  output logic [SQ_W-1:0]    mem_addr,
  output logic               mem_we,
  output logic [PIECE_W-1:0] mem_wdata,
  input  logic [PIECE_W-1:0] mem_rdata,
  output logic               done,
  output logic               ok,
  output logic [PIECE_W-1:0] captured,
  output logic               turn,
  output logic               king_taken
);

  localparam int unsigned ColBit = PIECE_W - 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdSrc,
    StRdDst,
    StCheck,
    StWrDst,
    StWrSrc,
    StDone
  } state_e;

  state_e             stateQ, stateD;
  logic [SQ_W-1:0]    srcQ, dstQ;
  logic [PIECE_W-1:0] srcPieceQ, dstPieceQ;
  logic               okQ, turnQ, kingTakenQ;
  logic [PIECE_W-1:0] capturedQ;
  logic               legal;
  logic [PIECE_W-1:0] wrPiece;

  // dst piece is taken straight from the RAM read port during CHECK
  assign legal = (srcPieceQ[2:0] != 3'd0) && (srcQ != dstQ) && (srcPieceQ[ColBit] == turnQ) &&
                 ((mem_rdata[2:0] == 3'd0) || (mem_rdata[ColBit] != srcPieceQ[ColBit]));

`ifdef AUTO_PROMOTE_EN
  logic [2:0] farRank;
  assign farRank = srcPieceQ[ColBit] ? 3'd0 : 3'd7;
  assign wrPiece = ((srcPieceQ[2:0] == 3'd1) && (dstQ[SQ_W-1 -: 3] == farRank)) ?
                   PIECE_W'({srcPieceQ[ColBit], 3'd5}) : srcPieceQ;
`else
  assign wrPiece = srcPieceQ;
`endif

  always_comb begin
    stateD    = stateQ;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    req_ready = 1'b0;
    done      = 1'b0;
    unique case (stateQ)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) stateD = StRdSrc;
      end
      StRdSrc: begin
        mem_addr = srcQ;
        stateD   = StRdDst;
      end
      StRdDst: begin
        mem_addr = dstQ;
        stateD   = StCheck;
      end
      StCheck: begin
        mem_addr = dstQ;
        stateD   = legal ? StWrDst : StDone;
      end
      StWrDst: begin
        mem_addr  = dstQ;
        mem_we    = 1'b1;
        mem_wdata = wrPiece;
        stateD    = StWrSrc;
      end
      StWrSrc: begin
        mem_addr = srcQ;
        mem_we   = 1'b1;
        stateD   = StDone;
      end
      StDone: begin
        done   = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= StIdle;
      srcQ       <= '0;
      dstQ       <= '0;
      srcPieceQ  <= '0;
      dstPieceQ  <= '0;
      okQ        <= 1'b0;
      capturedQ  <= '0;
      turnQ      <= START_TURN;
      kingTakenQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if ((stateQ == StIdle) && req_valid) begin
        srcQ <= req_src;
        dstQ <= req_dst;
      end
      if (stateQ == StRdDst) srcPieceQ <= mem_rdata;
      if (stateQ == StCheck) begin
        dstPieceQ <= mem_rdata;
        if (!legal) begin
          okQ       <= 1'b0;
          capturedQ <= '0;
        end
      end
      // Results become visible in the DONE cycle
      if (stateQ == StWrSrc) begin
        okQ       <= 1'b1;
        capturedQ <= dstPieceQ;
        turnQ     <= ~turnQ;
        if (dstPieceQ[2:0] == 3'd6) kingTakenQ <= 1'b1;
      end
    end
  end

  assign ok         = okQ;
  assign captured   = capturedQ;
  assign turn       = turnQ;
  assign king_taken = kingTakenQ;

endmodule

// File: tb/tb_move_commit_writer.sv
// Bench for move_commit_writer: directed vector table, abort-on-reset sequence and randomized moves
// checked against a board-level reference model. Honours AUTO_PROMOTE_EN like the design.
module tb_move_commit_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [5:0] req_src, req_dst, mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata, mem_rdata, captured;
  logic       done, ok, turn, king_taken;

  move_commit_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .ok        (ok),
    .captured  (captured),
    .turn      (turn),
    .king_taken(king_taken)
  );

  always #5 clk = ~clk;

  // Board RAM with registered read; the bench preloads it through a side port
  logic [3:0] ram [64];
  logic       preWe = 1'b0;
  logic [5:0] preAddr = '0;
  logic [3:0] preData = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (preWe) ram[preAddr] <= preData;
    mem_rdata <= ram[mem_addr];
  end

  int nChecks = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [3:0] d);
    preAddr = a;
    preData = d;
    preWe   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preWe = 1'b0;
  endtask

  // Issues one move from IDLE; cyc = cycles from accept edge to the done pulse
  task automatic doMove(input logic [5:0] s, input logic [5:0] d, output int cyc, output int wes,
                        output logic gotOk, output logic [3:0] gotCap, output logic pulseOk);
    req_src   = s;
    req_dst   = d;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    wes = 0;
    while (!done && cyc < 20) begin
      if (mem_we) wes++;
      @(negedge clk);
      cyc++;
    end
    gotOk  = ok;
    gotCap = captured;
    @(negedge clk);
    pulseOk = !done && req_ready;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] src, dst;
    logic [3:0] sp, dp;
    logic       expOk;
    logic [3:0] expCap;
    logic       expTurn, expKing;
    logic [3:0] expSrc, expDst;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] refBoard [64];

  initial begin
    int cyc, wes;
    logic gotOk, pulseOk;
    logic [3:0] gotCap, promoW, promoB, sp, dp, np;
    logic [5:0] s, d;
    logic refTurn, refKing, legal, seen;

`ifdef AUTO_PROMOTE_EN
    promoW = 4'h5;
    promoB = 4'hD;
`else
    promoW = 4'h1;
    promoB = 4'h9;
`endif
    //          src dst  sp    dp    ok    cap   turn  king  ramSrc ramDst
    vecs[0] = '{6'd12, 6'd28, 4'h1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 4'h1};
    vecs[1] = '{6'd57, 6'd42, 4'hA, 4'h1, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 4'hA};
    vecs[2] = '{6'd0,  6'd1,  4'h4, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 4'h4, 4'h2};
    vecs[3] = '{6'd20, 6'd21, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0};
    vecs[4] = '{6'd5,  6'd5,  4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1};
    vecs[5] = '{6'd48, 6'd40, 4'h9, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h9, 4'h0};
    vecs[6] = '{6'd3,  6'd59, 4'h5, 4'hE, 1'b1, 4'hE, 1'b1, 1'b1, 4'h0, 4'h5};
    vecs[7] = '{6'd50, 6'd42, 4'h9, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 4'h9};
    vecs[8] = '{6'd52, 6'd60, 4'h1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 4'h0, promoW};
    vecs[9] = '{6'd9,  6'd1,  4'h9, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, promoB};

    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    applyReset();
    check("rst req_ready", req_ready, 1);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst done", done, 0);
    check("rst ok", ok, 0);
    check("rst captured", captured, 0);
    check("rst turn", turn, 0);
    check("rst king_taken", king_taken, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      poke(vecs[i].dst, vecs[i].dp);
      poke(vecs[i].src, vecs[i].sp);
      doMove(vecs[i].src, vecs[i].dst, cyc, wes, gotOk, gotCap, pulseOk);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].expOk ? 6 : 4);
      check($sformatf("v%0d ok", i), gotOk, vecs[i].expOk);
      check($sformatf("v%0d captured", i), gotCap, vecs[i].expCap);
      check($sformatf("v%0d we cycles", i), wes, vecs[i].expOk ? 2 : 0);
      check($sformatf("v%0d pulse", i), pulseOk, 1);
      check($sformatf("v%0d turn", i), turn, vecs[i].expTurn);
      check($sformatf("v%0d king_taken", i), king_taken, vecs[i].expKing);
      check($sformatf("v%0d ram src", i), ram[vecs[i].src], vecs[i].expSrc);
      check($sformatf("v%0d ram dst", i), ram[vecs[i].dst], vecs[i].expDst);
      check($sformatf("v%0d ok held", i), ok, vecs[i].expOk);
    end

    // king_taken is cleared only by reset
    applyReset();
    check("rst2 king_taken", king_taken, 0);
    check("rst2 turn", turn, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort inside WR_DST
    poke(6'd28, 4'h0);
    poke(6'd12, 4'h1);
    doMove(6'd12, 6'd28, cyc, wes, gotOk, gotCap, pulseOk);
    check("abort pre turn", turn, 1);
    poke(6'd49, 4'h0);
    poke(6'd57, 4'hA);
    req_src   = 6'd57;
    req_dst   = 6'd49;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (mem_we) seen = 1'b1;
      else @(negedge clk);
    end
    check("abort reached WR_DST", seen, 1);
    check("abort wr addr", mem_addr, 49);
    rst_n = 1'b0;
    #1;
    check("abort mem_we", mem_we, 0);
    check("abort req_ready", req_ready, 1);
    check("abort turn", turn, 0);
    check("abort done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized moves against the board model
    refTurn = 1'b0;
    refKing = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int q = 0; q < 64; q++) begin
        np = ($urandom_range(0, 1) == 0) ? 4'h0 :
             {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))};
        refBoard[q] = np;
        poke(6'(q), np);
      end
      for (int m = 0; m < 12; m++) begin
        s = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          for (int t = 0; t < 16; t++) begin
            if (refBoard[s][2:0] != 0 && refBoard[s][3] == refTurn) break;
            s = 6'($urandom_range(0, 63));
          end
        end
        d = ($urandom_range(0, 9) == 0) ? s : 6'($urandom_range(0, 63));
        sp = refBoard[s];
        dp = refBoard[d];
        legal = sp[2:0] != 0 && s != d && sp[3] == refTurn && (dp[2:0] == 0 || dp[3] != sp[3]);
        np = sp;
`ifdef AUTO_PROMOTE_EN
        if (sp[2:0] == 3'd1 && ((!sp[3] && d / 8 == 7) || (sp[3] && d / 8 == 0))) np = {sp[3], 3'd5};
`endif
        doMove(s, d, cyc, wes, gotOk, gotCap, pulseOk);
        if (legal) begin
          refBoard[d] = np;
          refBoard[s] = 4'h0;
          refTurn = ~refTurn;
          if (dp[2:0] == 3'd6) refKing = 1'b1;
        end
        check($sformatf("r%0d.%0d cycles", b, m), cyc, legal ? 6 : 4);
        check($sformatf("r%0d.%0d ok", b, m), gotOk, legal);
        check($sformatf("r%0d.%0d captured", b, m), gotCap, legal ? dp : 4'h0);
        check($sformatf("r%0d.%0d we cycles", b, m), wes, legal ? 2 : 0);
        check($sformatf("r%0d.%0d pulse", b, m), pulseOk, 1);
        check($sformatf("r%0d.%0d turn", b, m), turn, refTurn);
        check($sformatf("r%0d.%0d king_taken", b, m), king_taken, refKing);
        check($sformatf("r%0d.%0d ram src", b, m), ram[s], refBoard[s]);
        check($sformatf("r%0d.%0d ram dst", b, m), ram[d], refBoard[d]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
